// File: rtl/snp_capture_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snp_capture_pkg : shared types/constants for the phase capture   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package snp_capture_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FILL  = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/snp_edge_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snp_edge_det : rising-edge detector, one-cycle pulse             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module snp_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule
`default_nettype wire

// File: rtl/snp_phs_ss_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snp_phs_ss_capture : phase snapshot burst writer, BRAM port A    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module snp_phs_ss_capture
  import snp_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_arm,
  input  logic              ctrl_circ,
  input  logic [ADDR_W-1:0] ctrl_post_len,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              status_done,
  output logic [ADDR_W-1:0] status_addr,
  output logic [ADDR_W-1:0] status_trig_addr,
  output logic              status_wrapped
);

  state_t            state;
  logic              arm_pulse;
  logic              circ_q;
  logic [ADDR_W-1:0] post_len_q;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              do_write;

  snp_edge_det u_arm_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (ctrl_arm),
    .pulse (arm_pulse)
  );

  // An arm pulse takes priority: the sample in that cycle is dropped.
  always_comb begin
    do_write = 1'b0;
    if (!arm_pulse && din_valid) begin
      case (state)
        ST_ARMED:         do_write = circ_q | trig;
        ST_FILL, ST_POST: do_write = 1'b1;
        default:          do_write = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      circ_q           <= 1'b0;
      post_len_q       <= '0;
      post_cnt         <= '0;
      wr_addr          <= '0;
      bram_we          <= 1'b0;
      bram_en_a        <= 1'b0;
      bram_addr        <= '0;
      bram_wr_data     <= '0;
      status_done      <= 1'b0;
      status_addr      <= '0;
      status_trig_addr <= '0;
      status_wrapped   <= 1'b0;
    end else begin
      bram_we   <= do_write;
      bram_en_a <= do_write;
      if (do_write) begin
        bram_addr    <= wr_addr;
        bram_wr_data <= din;
        status_addr  <= wr_addr;
        wr_addr      <= wr_addr + 1'b1;
        if (circ_q && wr_addr == '1) begin
          status_wrapped <= 1'b1;
        end
      end

      if (arm_pulse) begin
        state            <= ST_ARMED;
        circ_q           <= ctrl_circ;
        post_len_q       <= ctrl_post_len;
        post_cnt         <= '0;
        wr_addr          <= '0;
        status_done      <= 1'b0;
        status_wrapped   <= 1'b0;
        status_addr      <= '0;
        status_trig_addr <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ARMED: begin
            if (din_valid && trig) begin
              if (circ_q) begin
                status_trig_addr <= wr_addr;
                post_cnt         <= post_len_q;
                state            <= (post_len_q == '0) ? ST_DONE : ST_POST;
              end else begin
                state <= ST_FILL;
              end
            end
          end
          ST_FILL: begin
            if (din_valid && wr_addr == '1) begin
              state <= ST_DONE;
            end
          end
          ST_POST: begin
            if (din_valid) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == ADDR_W'(1)) begin
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: status_done <= 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/snp_phs_ss_capture.md
Name: snp_phs_ss_capture

Overview:
- Fabric-side writer for the phase snapshot shared BRAM. Captures a burst of 64-bit phase samples into BRAM port A (bram_we/bram_en_a/bram_addr/bram_wr_data).
- Exposes arm/trigger control and done/address status to the software registers.
- Software reads the captured data through the 32-bit bus port B; this block never touches port B.

Parameters:
- DATA_W, 64, sample and BRAM port A data width
- ADDR_W, 9, BRAM port A address width (depth 2**ADDR_W words)

Ports:
- clk  in  1  fabric clock, also the BRAM port A clock
- rst  in  1  asynchronous, active-high reset
- ctrl_arm  in  1  software arm bit; rising edge arms the capture
- ctrl_circ  in  1  0 = one-shot fill after trigger, 1 = circular pre-trigger capture
- ctrl_post_len  in  ADDR_W  words written after trigger in circular mode
- trig  in  1  external trigger, one-cycle qualified with din_valid
- din  in  DATA_W  phase sample word
- din_valid  in  1  din qualifier
- bram_we  out  1  port A write enable
- bram_en_a  out  1  port A enable
- bram_addr  out  ADDR_W  port A address
- bram_wr_data  out  DATA_W  port A write data
- status_done  out  1  capture complete, held until next arm
- status_addr  out  ADDR_W  last written address
- status_trig_addr  out  ADDR_W  address at which trigger sample was written
- status_wrapped  out  1  circular buffer wrapped at least once

Behaviour:
- Reset: async assert; all outputs 0; state IDLE; address counter 0; arm edge register 0.
- Arm detect: ctrl_arm registered once; arm_pulse = ctrl_arm & ~ctrl_arm_q.
- Write path registered: din/din_valid accepted in cycle N drive bram_we, bram_en_a = 1, bram_addr, bram_wr_data in cycle N+1 (latency 1). bram_en_a equals bram_we.
- States:
  - IDLE: no writes. arm_pulse -> clear status_done, status_wrapped, address counter; go to ARMED.
  - ARMED:
    - ctrl_circ = 0: no writes; first cycle with trig & din_valid -> write that sample at addr 0 and go to FILL.
    - ctrl_circ = 1: every din_valid writes and increments the address modulo 2**ADDR_W; wrap sets status_wrapped. trig & din_valid -> that sample is written, status_trig_addr latched with its address, post counter loaded with ctrl_post_len, go to POST.
  - FILL: each din_valid writes the next address. Write at addr 2**ADDR_W-1 is the last one -> DONE.
  - POST: each din_valid writes and decrements the post counter. When the counter reaches 0 after a write -> DONE.
    - ctrl_post_len = 0: the trigger sample is the final write.
    - Address wraps modulo depth; status_wrapped is updated as in ARMED.
  - DONE: status_done = 1; no writes; arm_pulse -> same action as in IDLE.
- status_addr tracks the address of the most recent write. In one-shot mode status_trig_addr = 0.
- arm_pulse in ARMED/FILL/POST restarts: counter cleared, status cleared, state ARMED; data already in flight still completes its registered write.
- trig without din_valid is ignored. trig in FILL/POST/DONE/IDLE is ignored.
- ctrl_circ and ctrl_post_len are sampled on arm_pulse and held for the capture.
- Mid-capture reset: writes stop immediately, state IDLE, BRAM contents undefined to software.

Decomposition:
- Package snp_capture_pkg holds:
  - the state enum (IDLE, ARMED, FILL, POST, DONE)
  - the ADDR_W/DATA_W defaults
  - the DEPTH = 2**ADDR_W constant
- Optional sub-module snp_edge_det for the arm rising-edge detector; everything else stays flat.

Test Plan:
- Reset during FILL at addr 100: bram_we = 0 the next cycle; status_* = 0; state IDLE; the next arm and trigger start at addr 0.
- One-shot: arm, din_valid continuous, trig at sample k with din=k:
  - bram writes addr 0..511 with data k..k+511
  - status_done rises the cycle after the addr-511 write
  - status_addr = 511
- Circular, post_len = 100, 1000 valid samples before trig:
  - status_wrapped = 1
  - status_trig_addr = 1000 mod 512 = 488
  - last write at (488+100) mod 512 = 76
  - status_addr = 76
- Circular, post_len = 0: trigger sample is the only post write; status_done rises one cycle after it.
- din_valid toggling 50%: address advances only on valid cycles, latency exactly 1 cycle; trig asserted with din_valid = 0 is ignored.
- Re-arm while in POST: status cleared, address restarts at 0; ctrl_circ change after arm has no effect until the next arm.
